// File: rtl/rf_access_arbiter_if.sv
// Bundle of the two requester ports and the register file pins around rf_access_arbiter.
// slave is the arbiter's view; master is the view of the requesters plus the register file.
interface rf_access_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  req0, req1;
  logic                  we0, we1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic                  gnt0, gnt1;
  logic                  ack0, ack1;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;
  logic                  err;
  logic                  busy;
  logic                  rf_wr_en, rf_rd_en;
  logic [ADDR_WIDTH-1:0] rf_addr;
  logic [DATA_WIDTH-1:0] rf_wr_data;
  logic [DATA_WIDTH-1:0] rf_rd_data;
  logic                  rf_rd_valid;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, rf_rd_data, rf_rd_valid,
    output gnt0, gnt1, ack0, ack1, rdata0, rdata1, err, busy,
           rf_wr_en, rf_rd_en, rf_addr, rf_wr_data
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, rf_rd_data, rf_rd_valid,
    input  gnt0, gnt1, ack0, ack1, rdata0, rdata1, err, busy,
           rf_wr_en, rf_rd_en, rf_addr, rf_wr_data
  );
endinterface

// File: rtl/rf_access_arbiter.sv
// Round-robin single-port register file arbiter: gnt/strobe 1 cycle after req, write ack at 2, read ack 1 after rf_rd_valid.
// Requests wait (held high) while busy; optional read timeout with err pulse when RF_ARB_TIMEOUT_EN is defined.
module rf_access_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 15
) (
  input logic                CLK,
  input logic                RST,
  rf_access_arbiter_if.slave bus
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("rf_access_arbiter: TIMEOUT must be within 1..255");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DONE = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  last_q, last_d;
  logic                  owner_q, owner_d;
  logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                  ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  rf_wr_en_q, rf_wr_en_d, rf_rd_en_q, rf_rd_en_d;
  logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0] rf_wr_data_q, rf_wr_data_d;
  logic                  busy_q, busy_d;
  logic                  done;

  logic                  win_vld, win_idx, win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

`ifdef RF_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  // On contention the requester that did not win last time goes first.
  assign win_vld   = bus.req0 | bus.req1;
  assign win_idx   = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
  assign win_we    = win_idx ? bus.we1    : bus.we0;
  assign win_addr  = win_idx ? bus.addr1  : bus.addr0;
  assign win_wdata = win_idx ? bus.wdata1 : bus.wdata0;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    owner_d      = owner_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    done         = 1'b0;
`ifdef RF_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (win_vld) begin
          last_d    = win_idx;
          owner_d   = win_idx;
          gnt0_d    = ~win_idx;
          gnt1_d    = win_idx;
          rf_addr_d = win_addr;
          if (win_we) begin
            rf_wr_data_d = win_wdata;
            rf_wr_en_d   = 1'b1;
            state_d      = WR_DONE;
          end else begin
            rf_rd_en_d = 1'b1;
`ifdef RF_ARB_TIMEOUT_EN
            cnt_d      = '0;
`endif
            state_d    = RD_WAIT;
          end
        end
      end
      WR_DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      RD_WAIT: begin
        // Returned data wins over a timeout landing on the same cycle.
        if (bus.rf_rd_valid) begin
          if (owner_q) rdata1_d = bus.rf_rd_data;
          else         rdata0_d = bus.rf_rd_data;
          done    = 1'b1;
          state_d = IDLE;
        end
`ifdef RF_ARB_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT)) begin
          if (owner_q) rdata1_d = '0;
          else         rdata0_d = '0;
          err_d   = 1'b1;
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    ack0_d = done & ~owner_q;
    ack1_d = done & owner_q;
    // busy spans grant through the completion pulse.
    busy_d = (state_d != IDLE) | done;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      owner_q      <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      owner_q      <= owner_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      busy_q       <= busy_d;
    end
  end

`ifdef RF_ARB_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.gnt0       = gnt0_q;
  assign bus.gnt1       = gnt1_q;
  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.rdata0     = rdata0_q;
  assign bus.rdata1     = rdata1_q;
  assign bus.rf_wr_en   = rf_wr_en_q;
  assign bus.rf_rd_en   = rf_rd_en_q;
  assign bus.rf_addr    = rf_addr_q;
  assign bus.rf_wr_data = rf_wr_data_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed bench for rf_access_arbiter: transaction-level model checked every cycle plus literal spot checks.
module tb_rf_access_arbiter;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TO = 15;
`ifdef RF_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  rf_access_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  rf_access_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Register file: memory, configurable read latency (0 = never answers), spurious valid pulse.
  logic [DW-1:0] mem [16];
  int            rd_lat = 1;
  int            pend = 0;
  logic [AW-1:0] pend_addr = '0;
  bit            spur = 1'b0;
  always @(negedge CLK) begin
    bus.rf_rd_data  = 8'hEE;
    bus.rf_rd_valid = spur;
    if (!RST) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.rf_rd_valid = 1'b1;
          bus.rf_rd_data  = mem[pend_addr];
        end
      end
      if (bus.rf_wr_en) mem[bus.rf_addr] = bus.rf_wr_data;
      if (bus.rf_rd_en && rd_lat > 0) begin
        pend      = rd_lat;
        pend_addr = bus.rf_addr;
      end
    end
  end

  // Model: one transaction in flight, aged in cycles since its grant.
  logic e_gnt0 = 0, e_gnt1 = 0, e_ack0 = 0, e_ack1 = 0, e_err = 0, e_wr = 0, e_rd = 0, e_busy = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wd = '0, e_rd0 = '0, e_rd1 = '0;
  bit inflight = 0, is_rd = 0, done = 0;
  int owner = 0, age = 0, prev = 1, w = 0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      {e_gnt0, e_gnt1, e_ack0, e_ack1, e_err, e_wr, e_rd, e_busy} = '0;
      e_addr = '0; e_wd = '0; e_rd0 = '0; e_rd1 = '0;
      inflight = 0; prev = 1; age = 0;
    end else begin
      {e_gnt0, e_gnt1, e_ack0, e_ack1, e_err, e_wr, e_rd} = '0;
      done = 0;
      if (inflight) begin
        age++;
        if (!is_rd) done = (age == 1);
        else if (bus.rf_rd_valid) begin
          done = 1;
          if (owner == 0) e_rd0 = bus.rf_rd_data; else e_rd1 = bus.rf_rd_data;
        end else if (TO_EN && age == TO + 1) begin
          done = 1; e_err = 1;
          if (owner == 0) e_rd0 = '0; else e_rd1 = '0;
        end
        if (done) begin
          if (owner == 0) e_ack0 = 1; else e_ack1 = 1;
          inflight = 0;
        end
      end else if (bus.req0 || bus.req1) begin
        w = (bus.req0 && bus.req1) ? 1 - prev : (bus.req0 ? 0 : 1);
        prev = w; owner = w; inflight = 1; age = 0;
        if (w == 0) e_gnt0 = 1; else e_gnt1 = 1;
        e_addr = (w == 0) ? bus.addr0 : bus.addr1;
        is_rd = (w == 0) ? !bus.we0 : !bus.we1;
        if (is_rd) e_rd = 1;
        else begin
          e_wr = 1;
          e_wd = (w == 0) ? bus.wdata0 : bus.wdata1;
        end
      end
      e_busy = inflight || e_ack0 || e_ack1;
    end
  end

  always @(negedge CLK) begin
    chk("gnt0", bus.gnt0, e_gnt0);
    chk("gnt1", bus.gnt1, e_gnt1);
    chk("ack0", bus.ack0, e_ack0);
    chk("ack1", bus.ack1, e_ack1);
    chk("err", bus.err, e_err);
    chk("rf_wr_en", bus.rf_wr_en, e_wr);
    chk("rf_rd_en", bus.rf_rd_en, e_rd);
    chk("rf_addr", bus.rf_addr, e_addr);
    chk("rf_wr_data", bus.rf_wr_data, e_wd);
    chk("rdata0", bus.rdata0, e_rd0);
    chk("rdata1", bus.rdata1, e_rd1);
    chk("busy", bus.busy, e_busy);
  end

  // Event log: grant order and cycle of the latest grant/ack per requester.
  int gq[$];
  int g_cyc[2] = '{0, 0};
  int a_cyc[2] = '{0, 0};
  int n_ack = 0;
  bit err_at_ack = 0;
  always @(negedge CLK) begin
    if (bus.gnt0) begin gq.push_back(0); g_cyc[0] = cyc; end
    if (bus.gnt1) begin gq.push_back(1); g_cyc[1] = cyc; end
    if (bus.ack0) begin a_cyc[0] = cyc; n_ack++; err_at_ack = bus.err; end
    if (bus.ack1) begin a_cyc[1] = cyc; n_ack++; err_at_ack = bus.err; end
  end

  // Called at a negedge: raise req, hold until gnt, drop, return one negedge later.
  task automatic do_req(input int r, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int  n = 0;
    bit  got = 0;
    if (r == 0) begin bus.req0 = 1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; end
    else        begin bus.req1 = 1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; end
    while (!got && n < 200) begin
      @(negedge CLK);
      n++;
      got = (r == 0) ? bus.gnt0 : bus.gnt1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL gnt_wait r=%0d: no grant within %0d cycles", r, n);
    end
    if (r == 0) bus.req0 = 0; else bus.req1 = 0;
    @(negedge CLK);
  endtask

  task automatic wait_ack(input int r);
    int n = 0;
    while (!((r == 0) ? bus.ack0 : bus.ack1) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL ack_wait r=%0d: no ack within %0d cycles", r, n);
    end
    @(negedge CLK);
  endtask

  int snap;
  int exp_order [8] = '{0, 1, 0, 1, 0, 1, 0, 1};

  initial begin
    {bus.req0, bus.req1, bus.we0, bus.we1} = '0;
    {bus.addr0, bus.addr1, bus.wdata0, bus.wdata1} = '0;
    bus.rf_rd_data = '0; bus.rf_rd_valid = 0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    #3 RST = 0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rf_addr", bus.rf_addr, 0);
    chk("rst_gnt0", bus.gnt0, 0);
    RST = 1;
    @(negedge CLK);

    // Write from requester 0.
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 4'h3; bus.wdata0 = 8'h5A;
    @(negedge CLK);
    chk("w_gnt0_c1", bus.gnt0, 1);
    chk("w_wr_en_c1", bus.rf_wr_en, 1);
    chk("w_addr_c1", bus.rf_addr, 4'h3);
    chk("w_wdata_c1", bus.rf_wr_data, 8'h5A);
    chk("w_busy_c1", bus.busy, 1);
    bus.req0 = 0;
    @(negedge CLK);
    chk("w_ack0_c2", bus.ack0, 1);
    chk("w_busy_c2", bus.busy, 1);
    chk("w_wr_en_c2", bus.rf_wr_en, 0);
    @(negedge CLK);
    chk("w_busy_c3", bus.busy, 0);

    // Read from requester 1, 1-cycle RF.
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 4'h3;
    @(negedge CLK);
    chk("r_gnt1_c1", bus.gnt1, 1);
    chk("r_rd_en_c1", bus.rf_rd_en, 1);
    bus.req1 = 0;
    @(negedge CLK);
    chk("r_ack1_c2", bus.ack1, 0);
    @(negedge CLK);
    chk("r_ack1_c3", bus.ack1, 1);
    chk("r_rdata1_c3", bus.rdata1, 8'h5A);
    @(negedge CLK);
    chk("r_rdata1_hold", bus.rdata1, 8'h5A);

    // rf_rd_valid while idle is ignored.
    snap = n_ack;
    #2 spur = 1;
    @(negedge CLK);
    #2 spur = 0;
    repeat (2) @(negedge CLK);
    chk("spur_no_ack", n_ack, snap);
    chk("spur_rdata1", bus.rdata1, 8'h5A);

    // Both requesters writing continuously: strict alternation starting with 0.
    gq.delete();
    fork
      for (int i = 0; i < 4; i++) do_req(0, 1, 4'h0, 8'(8'h10 + i));
      for (int j = 0; j < 4; j++) do_req(1, 1, 4'h1, 8'(8'h20 + j));
    join
    chk("rr_count", gq.size(), 8);
    for (int k = 0; k < 8 && k < gq.size(); k++) chk($sformatf("rr_order%0d", k), gq[k], exp_order[k]);
    @(negedge CLK);

    // Requester 1 waits behind a slow read from requester 0.
    rd_lat = 5;
    fork
      do_req(0, 0, 4'h1, 8'h00);
      begin
        repeat (2) @(negedge CLK);
        do_req(1, 1, 4'h5, 8'h77);
      end
    join
    @(negedge CLK);
    chk("slow_ack0_lat", a_cyc[0] - g_cyc[0], 6);
    chk("slow_gnt1_after", g_cyc[1] - g_cyc[0], 7);
    chk("slow_rdata0", bus.rdata0, 8'h23);
    rd_lat = 1;

`ifdef RF_ARB_TIMEOUT_EN
    // Read that never completes times out with err and zero data.
    rd_lat = 0;
    do_req(0, 0, 4'h7, 8'h00);
    wait_ack(0);
    chk("to_ack_lat", a_cyc[0] - g_cyc[0], 16);
    chk("to_err", err_at_ack, 1);
    chk("to_rdata0", bus.rdata0, 8'h00);
    rd_lat = 1;
    do_req(0, 1, 4'h2, 8'h33);
    wait_ack(0);
    chk("to_resume_lat", a_cyc[0] - g_cyc[0], 1);
    chk("to_resume_err", err_at_ack, 0);
`endif

    // Asynchronous reset while a read is outstanding.
    rd_lat = 0;
    do_req(0, 0, 4'h4, 8'h00);
    @(posedge CLK);
    #2 RST = 0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_rd_en", bus.rf_rd_en, 0);
    chk("arst_rf_addr", bus.rf_addr, 0);
    chk("arst_rdata1", bus.rdata1, 0);
    chk("arst_ack0", bus.ack0, 0);
    snap = n_ack;
    repeat (2) @(negedge CLK);
    RST = 1;
    rd_lat = 1;
    repeat (5) @(negedge CLK);
    chk("arst_no_ack", n_ack, snap);
    do_req(0, 1, 4'h9, 8'hC3);
    wait_ack(0);
    chk("arst_resume_lat", a_cyc[0] - g_cyc[0], 1);
    chk("arst_mem", mem[9], 8'hC3);

    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule
